// File: rtl/msrv32_pkg.sv
// Shared constants and flattened-bus helpers for the msrv32 integer register file.
package msrv32_pkg;

    localparam int XLEN        = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int REG_DEPTH   = 32;
    localparam int SLICE_MAX_W = 64;
    localparam int BUS_MAX_W   = 256;

    // Slice k of width w from a flattened bus; the caller truncates the result to w bits.
    function automatic logic [SLICE_MAX_W-1:0] bus_slice(
        input logic [BUS_MAX_W-1:0] bus,
        input int                   k,
        input int                   w
    );
        return SLICE_MAX_W'(bus >> (k * w));
    endfunction

endpackage

// File: rtl/msrv32_wr_arbiter.sv
// Write-port arbiter for one target address: highest-index valid port wins,
// and two or more valid ports on the same address flag a collision.
module msrv32_wr_arbiter
    import msrv32_pkg::*;
#(
    parameter int WIDTH      = XLEN,
    parameter int DEPTH      = REG_DEPTH,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic [ADDR_WIDTH-1:0]        match_addr,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*WIDTH-1:0]      wr_data,
    output logic                         hit,
    output logic [WIDTH-1:0]             data,
    output logic                         collision
);

    logic [ADDR_WIDTH-1:0] addr_w [NUM_WR];
    logic [WIDTH-1:0]      data_w [NUM_WR];
    logic [NUM_WR-1:0]     match;

    for (genvar w = 0; w < NUM_WR; w++) begin : g_port
        assign addr_w[w] = ADDR_WIDTH'(bus_slice(BUS_MAX_W'(wr_addr), w, ADDR_WIDTH));
        assign data_w[w] = WIDTH'(bus_slice(BUS_MAX_W'(wr_data), w, WIDTH));
        // Writes to x0 (when hardwired) and beyond DEPTH are dropped before arbitration.
        assign match[w]  = wr_en[w]
                         && (addr_w[w] == match_addr)
                         && !(ZERO_REG != 0 && addr_w[w] == '0)
                         && (32'(addr_w[w]) < DEPTH);
    end

    always_comb begin
        hit       = 1'b0;
        data      = '0;
        collision = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (match[w]) begin
                if (hit) collision = 1'b1;
                hit  = 1'b1;
                data = data_w[w];
            end
        end
    end

endmodule

// File: rtl/msrv32_integer_file_mp.sv
// Multi-port integer register file with prioritised writeback, optional
// write-to-read bypass, per-register busy scoreboard and sticky collision flag.
module msrv32_integer_file_mp
    import msrv32_pkg::*;
#(
    parameter int WIDTH      = XLEN,
    parameter int DEPTH      = REG_DEPTH,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         msrv32_mp_clk_in,
    input  logic                         msrv32_mp_rst_in,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rs_addr_in,
    input  logic [NUM_RD-1:0]            rs_valid_in,
    output logic [NUM_RD*WIDTH-1:0]      rs_out,
    output logic [NUM_RD-1:0]            rs_busy_out,
    output logic                         hazard_out,
    input  logic [NUM_WR-1:0]            wr_en_in,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] rd_addr_in,
    input  logic [NUM_WR*WIDTH-1:0]      rd_in,
    input  logic                         issue_en_in,
    input  logic [ADDR_WIDTH-1:0]        issue_rd_in,
    output logic [DEPTH-1:0]             busy_vec_out,
    output logic                         collision_err_out
);

    logic [WIDTH-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              collision;
    logic [DEPTH-1:0]  wr_hit;
    logic [DEPTH-1:0]  wr_coll;
    logic [WIDTH-1:0]  wr_data [DEPTH];
    logic [NUM_RD-1:0] byp_hit;
    logic [NUM_RD-1:0] byp_coll;
    logic [WIDTH-1:0]  byp_data [NUM_RD];
    logic              issue_ok;

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        msrv32_wr_arbiter #(
            .WIDTH      (WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .NUM_WR     (NUM_WR),
            .ZERO_REG   (ZERO_REG)
        ) u_wr_arb (
            .match_addr (ADDR_WIDTH'(i)),
            .wr_en      (wr_en_in),
            .wr_addr    (rd_addr_in),
            .wr_data    (rd_in),
            .hit        (wr_hit[i]),
            .data       (wr_data[i]),
            .collision  (wr_coll[i])
        );
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  in_range;
        logic                  is_zero;
        logic                  use_byp;

        assign addr     = ADDR_WIDTH'(bus_slice(BUS_MAX_W'(rs_addr_in), r, ADDR_WIDTH));
        assign in_range = 32'(addr) < DEPTH;
        assign is_zero  = (ZERO_REG != 0) && (addr == '0);
        assign use_byp  = (BYPASS != 0) && !msrv32_mp_rst_in && byp_hit[r];

        msrv32_wr_arbiter #(
            .WIDTH      (WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .NUM_WR     (NUM_WR),
            .ZERO_REG   (ZERO_REG)
        ) u_byp_arb (
            .match_addr (addr),
            .wr_en      (wr_en_in),
            .wr_addr    (rd_addr_in),
            .wr_data    (rd_in),
            .hit        (byp_hit[r]),
            .data       (byp_data[r]),
            .collision  (byp_coll[r])
        );

        assign rs_out[r*WIDTH +: WIDTH] = (!in_range || is_zero) ? '0
                                        : (use_byp ? byp_data[r] : regs[addr]);
        // A result landing this cycle releases the operand only when it is forwarded.
        assign rs_busy_out[r] = in_range && !is_zero && !msrv32_mp_rst_in && busy[addr]
                              && !((BYPASS != 0) && byp_hit[r]);
    end

    assign hazard_out = |(rs_valid_in & rs_busy_out);

    assign issue_ok = issue_en_in
                    && !(ZERO_REG != 0 && issue_rd_in == '0)
                    && (32'(issue_rd_in) < DEPTH);

    always_ff @(posedge msrv32_mp_clk_in) begin
        if (msrv32_mp_rst_in) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy      <= '0;
            collision <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) regs[i] <= wr_data[i];
                // A fresh issue beats a same-cycle writeback: the new producer is still in flight.
                if (issue_ok && issue_rd_in == ADDR_WIDTH'(i)) busy[i] <= 1'b1;
                else if (wr_hit[i])                            busy[i] <= 1'b0;
            end
            if (|wr_coll || |byp_coll) collision <= 1'b1;
        end
    end

    assign busy_vec_out      = busy;
    assign collision_err_out = collision;

endmodule

// File: tb/tb_msrv32_integer_file_mp.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural register-file/scoreboard model (NUM_RD=2, NUM_WR=2, BYPASS=1, ZERO_REG=1).
module tb_msrv32_integer_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra [2];
    logic [1:0]  rs_valid;
    logic [63:0] rs_out;
    logic [1:0]  rs_busy;
    logic        hazard;
    logic [1:0]  we;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [31:0] busy_vec;
    logic        coll;

    logic [9:0]  rs_addr_bus;
    logic [9:0]  rd_addr_bus;
    logic [63:0] rd_bus;

    assign rs_addr_bus = {ra[1], ra[0]};
    assign rd_addr_bus = {wa[1], wa[0]};
    assign rd_bus      = {wd[1], wd[0]};

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [32];
    bit          busy_m [32];
    bit          coll_m;

    always #5 clk = ~clk;

    msrv32_integer_file_mp #(
        .WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .msrv32_mp_clk_in  (clk),
        .msrv32_mp_rst_in  (rst),
        .rs_addr_in        (rs_addr_bus),
        .rs_valid_in       (rs_valid),
        .rs_out            (rs_out),
        .rs_busy_out       (rs_busy),
        .hazard_out        (hazard),
        .wr_en_in          (we),
        .rd_addr_in        (rd_addr_bus),
        .rd_in             (rd_bus),
        .issue_en_in       (issue_en),
        .issue_rd_in       (issue_rd),
        .busy_vec_out      (busy_vec),
        .collision_err_out (coll)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latest port in order overrides earlier ones, giving highest-index priority.
    function automatic bit wr_to(input logic [4:0] a, output logic [31:0] d);
        bit h;
        h = 1'b0;
        d = '0;
        for (int w = 0; w < 2; w++) begin
            if (we[w] && wa[w] != 5'd0 && wa[w] == a) begin
                h = 1'b1;
                d = wd[w];
            end
        end
        return h;
    endfunction

    function automatic logic [4:0] pick_addr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    endfunction

    task automatic idle();
        rst      = 1'b0;
        we       = 2'b00;
        issue_en = 1'b0;
        rs_valid = 2'b00;
    endtask

    // Check the combinational outputs for the inputs currently applied.
    task automatic settle();
        logic [31:0] d;
        logic [31:0] exp;
        logic [1:0]  eb;
        bit          h;
        #1;
        eb = '0;
        for (int r = 0; r < 2; r++) begin
            h = wr_to(ra[r], d);
            if (ra[r] == 5'd0)   exp = '0;
            else if (!rst && h)  exp = d;
            else                 exp = mem[ra[r]];
            eb[r] = !rst && ra[r] != 5'd0 && !h && busy_m[ra[r]];
            chk($sformatf("rs_out%0d", r), 64'(rs_out[r*32 +: 32]), 64'(exp));
        end
        chk("rs_busy", 64'(rs_busy), 64'(eb));
        chk("hazard", 64'(hazard), 64'(|(rs_valid & eb)));
    endtask

    // Advance the model and the DUT by one edge, then check registered state.
    task automatic clock();
        logic [31:0] bv;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem[i]    = '0;
                busy_m[i] = 1'b0;
            end
            coll_m = 1'b0;
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (we[w] && wa[w] != 5'd0) begin
                    mem[wa[w]]    = wd[w];
                    busy_m[wa[w]] = 1'b0;
                end
            end
            if (we == 2'b11 && wa[0] == wa[1] && wa[0] != 5'd0) coll_m = 1'b1;
            if (issue_en && issue_rd != 5'd0) busy_m[issue_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) bv[i] = busy_m[i];
        chk("busy_vec", 64'(busy_vec), 64'(bv));
        chk("collision", 64'(coll), 64'(coll_m));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]    = '0;
            busy_m[i] = 1'b0;
        end
        coll_m   = 1'b0;
        ra[0]    = '0;
        ra[1]    = '0;
        wa[0]    = '0;
        wa[1]    = '0;
        wd[0]    = '0;
        wd[1]    = '0;
        issue_rd = '0;
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset, then every register reads zero with no busy or collision state.
        rst = 1'b1;
        we  = 2'b11; wa[0] = 5'd3; wd[0] = 32'hFFFF_FFFF; wa[1] = 5'd4; wd[1] = 32'h1;
        issue_en = 1'b1; issue_rd = 5'd6;
        settle();
        clock();
        chk("t1_busy_vec", 64'(busy_vec), 64'd0);
        chk("t1_coll", 64'(coll), 64'd0);
        idle();
        for (int i = 1; i < 32; i++) begin
            ra[0] = 5'(i);
            ra[1] = 5'(32 - i);
            settle();
            chk("t1_rd0", 64'(rs_out[31:0]), 64'd0);
            chk("t1_rd1", 64'(rs_out[63:32]), 64'd0);
            clock();
        end

        // Same-cycle bypass of a write, then the array value next cycle.
        idle();
        we = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEAD_BEEF; ra[1] = 5'd5;
        settle();
        chk("t2_bypass", 64'(rs_out[63:32]), 64'hDEAD_BEEF);
        clock();
        idle();
        settle();
        chk("t2_array", 64'(rs_out[63:32]), 64'hDEAD_BEEF);
        clock();

        // x0 ignores writes and issue.
        we = 2'b01; wa[0] = 5'd0; wd[0] = 32'h1234; issue_en = 1'b1; issue_rd = 5'd0; ra[0] = 5'd0;
        settle();
        chk("t3_x0_byp", 64'(rs_out[31:0]), 64'd0);
        clock();
        chk("t3_busy0", 64'(busy_vec[0]), 64'd0);
        idle();
        settle();
        chk("t3_x0", 64'(rs_out[31:0]), 64'd0);
        clock();

        // Two ports on x7: port 1 wins, collision is sticky.
        we = 2'b11; wa[0] = 5'd7; wd[0] = 32'h11; wa[1] = 5'd7; wd[1] = 32'h22; ra[0] = 5'd7;
        settle();
        chk("t4_byp", 64'(rs_out[31:0]), 64'h22);
        clock();
        chk("t4_coll", 64'(coll), 64'd1);
        idle();
        repeat (3) begin
            settle();
            clock();
        end
        chk("t4_sticky", 64'(coll), 64'd1);
        settle();
        chk("t4_x7", 64'(rs_out[31:0]), 64'h22);
        clock();

        // Issue x9, stall on it, then release through writeback bypass.
        issue_en = 1'b1; issue_rd = 5'd9;
        settle();
        clock();
        idle();
        ra[0] = 5'd9; rs_valid = 2'b01;
        repeat (3) begin
            settle();
            chk("t5_hazard", 64'(hazard), 64'd1);
            clock();
        end
        we = 2'b01; wa[0] = 5'd9; wd[0] = 32'h55;
        settle();
        chk("t5_release", 64'(hazard), 64'd0);
        chk("t5_data", 64'(rs_out[31:0]), 64'h55);
        clock();
        chk("t5_busy9", 64'(busy_vec[9]), 64'd0);

        // Issue and writeback of x9 together: busy stays set; reset clears all.
        idle();
        issue_en = 1'b1; issue_rd = 5'd9; we = 2'b01; wa[0] = 5'd9; wd[0] = 32'h66;
        settle();
        clock();
        chk("t6_busy9", 64'(busy_vec[9]), 64'd1);
        idle();
        rst = 1'b1; ra[0] = 5'd9; ra[1] = 5'd7; rs_valid = 2'b11;
        settle();
        chk("t6_rst_hazard", 64'(hazard), 64'd0);
        clock();
        chk("t6_rst_busy", 64'(busy_vec), 64'd0);
        chk("t6_rst_coll", 64'(coll), 64'd0);
        idle();
        settle();
        chk("t6_x9", 64'(rs_out[31:0]), 64'd0);
        chk("t6_x7", 64'(rs_out[63:32]), 64'd0);
        clock();

        // Randomized traffic against the model.
        repeat (600) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int w = 0; w < 2; w++) begin
                we[w] = ($urandom_range(0, 2) != 0);
                wa[w] = pick_addr();
                wd[w] = $urandom;
            end
            issue_en = 1'($urandom_range(0, 1));
            issue_rd = pick_addr();
            ra[0]    = pick_addr();
            ra[1]    = pick_addr();
            rs_valid = 2'($urandom);
            settle();
            clock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/msrv32_integer_file_mp.md
Name: msrv32_integer_file_mp

Overview:
Multi-port integer register file with a built-in scoreboard. It is parametrised in width, depth, read-port count and write-port count. It adds prioritised multi-port writeback, optional write-to-read bypass, per-register busy tracking for in-flight multi-cycle results, and a sticky write-collision flag. It sits between the decode/issue stage and the writeback stage of the msrv32 core and drives the operand-hazard stall.

Parameters:
WIDTH, 32, data width of each register
DEPTH, 32, number of registers
ADDR_WIDTH, 5, register address width; DEPTH <= 2**ADDR_WIDTH
NUM_RD, 2, number of read ports
NUM_WR, 1, number of write ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes to it dropped, never busy)

Ports:
msrv32_mp_clk_in  in  1  clock; all state updates on rising edge
msrv32_mp_rst_in  in  1  reset, synchronous, active-high
rs_addr_in  in  NUM_RD*ADDR_WIDTH  read addresses; port r occupies slice [r*ADDR_WIDTH +: ADDR_WIDTH]
rs_valid_in  in  NUM_RD  read port r is actually used by the issuing instruction
rs_out  out  NUM_RD*WIDTH  read data, combinational
rs_busy_out  out  NUM_RD  per-port operand not yet available
hazard_out  out  1  OR over r of (rs_valid_in[r] & rs_busy_out[r])
wr_en_in  in  NUM_WR  write enables
rd_addr_in  in  NUM_WR*ADDR_WIDTH  write addresses
rd_in  in  NUM_WR*WIDTH  write data
issue_en_in  in  1  mark issue_rd_in as pending a result
issue_rd_in  in  ADDR_WIDTH  destination of the issuing instruction
busy_vec_out  out  DEPTH  registered busy bits, for debug and CSR visibility
collision_err_out  out  1  sticky; set when two enabled write ports target the same non-dropped address

Behaviour:
- Reset (rising edge with msrv32_mp_rst_in=1):
  - All registers become 0, busy_vec_out becomes 0, collision_err_out becomes 0.
  - Writes and issue in that cycle are ignored.
  - While reset is high, the bypass is suppressed and rs_busy_out = 0.
- Write valid condition: wr_en_in[w] & !(ZERO_REG & addr==0) & addr<DEPTH.
- Write priority: if several valid writes target the same address, the highest-index port wins. The array updates one cycle later (visible after the edge).
- Register 0 with ZERO_REG=1: reads always return 0 and it is never busy.
- Read data:
  - rs_out[r] = data of the winning valid write port whose address equals rs_addr_in[r], if BYPASS=1.
  - Otherwise rs_out[r] = array[rs_addr_in[r]].
  - Any out-of-range address reads 0.
- Scoreboard, next-state per register i:
  - busy[i] <= (issue_en_in & issue_rd_in==i & valid dest) ? 1 : (any valid write to i ? 0 : busy[i]).
  - A set and a clear of the same register in the same cycle: set wins, because the new producer is in flight.
  - Issue to register 0 with ZERO_REG=1 is dropped.
- rs_busy_out[r]: busy[rs_addr_in[r]], except when BYPASS=1 and a valid write to that address occurs this cycle; then it is 0. With BYPASS=0, busy remains through that cycle.
- hazard_out: purely combinational from the terms above; no added latency.
- collision_err_out: set on the edge after any cycle with two or more valid writes to the same address. It holds until reset.
- Latency summary: read 0 cycles (combinational), write 1 cycle, busy set/clear 1 cycle.

Decomposition:
- Shared package msrv32_pkg holds:
  - constants XLEN=32, REG_ADDR_W=5, REG_DEPTH=32;
  - a function that extracts slice k of a flattened port bus.
- One natural sub-module: msrv32_wr_arbiter. It is combinational and, per address match, produces the winning write enable/data and the collision detect. It is instantiated once per read port for the bypass and once for the array write.

Test Plan:
1. Reset, then read x1..x31 on both ports -> rs_out=0, busy_vec_out=0, collision_err_out=0.
2. Write x5=0xDEADBEEF via port 0 while reading x5 on port 1 -> rs_out[1]=0xDEADBEEF in the same cycle with BYPASS=1. With BYPASS=0, old value 0 in the same cycle, then 0xDEADBEEF next cycle.
3. Write x0=0x1234 and issue_rd=0 -> x0 reads 0, busy_vec_out[0]=0.
4. NUM_WR=2: port0 x7=0x11, port1 x7=0x22 in one cycle -> x7=0x22, collision_err_out=1 next cycle; it stays 1 until reset.
5. Issue x9, then read x9 with rs_valid=1 -> hazard_out=1 for 3 idle cycles. Writeback x9=0x55 -> hazard_out=0 that cycle (BYPASS=1) and rs_out=0x55. busy_vec_out[9]=0 the following cycle.
6. Same cycle: issue x9 plus writeback x9 -> busy[9] remains 1. Assert reset mid-sequence -> next cycle all registers 0 and busy=0.
